// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 RS-232 transmitter with a built-in baud timer.
// Bytes arrive on a valid/ready handshake, wait in a small FIFO and are shifted
// out LSB first. Frames with queued data follow each other with no idle gap.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid,
  input  logic [7:0]         tx_data,
  output logic               tx_ready,
  output logic               rs232_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               overflow
);

  localparam int unsigned BPS_CNT = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;
  localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_cnt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_overflow;

  logic                 w_full;
  logic                 w_has_data;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic [2:0]           w_next_idx;
  logic [7:0]           w_head;

  // FIFO status, handshake and pop request from the serialiser
  always_comb begin
    w_full     = (r_cnt == FULL_CNT);
    w_has_data = (r_cnt != '0);
    w_push     = tx_valid && !w_full;
    w_bit_end  = (r_bit_cnt == BIT_LAST);
    w_pop      = w_has_data &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    w_next_idx = r_bit_idx + 3'd1;
    w_head     = r_mem[r_rd_ptr];
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the registered overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= tx_valid && w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (FIFO_AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (FIFO_AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Frame FSM; line level and busy are set on the edge that enters each bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_shift[w_next_idx];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    tx_ready = !w_full;
    rs232_tx = r_tx;
    tx_busy  = r_busy;
    fifo_cnt = r_cnt;
    overflow = r_overflow;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timeline model checked every cycle, directed
// literal checks for the key scenarios, and a bit-centre sampling receiver.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int FIFO_AW  = 2;
  localparam int BPS      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 2 ** FIFO_AW;
  localparam int FRAME    = 10 * BPS;

  logic               clk;
  logic               rst_n;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               rs232_tx;
  logic               tx_busy;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               overflow;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rs232_tx (rs232_tx),
    .tx_busy  (tx_busy),
    .fifo_cnt (fifo_cnt),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of waiting bytes plus position inside the current frame
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  int         m_t;
  bit         m_busy;
  bit         m_ovf;
  int         m_pre;
  bit         m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 0;
      m_t    = 0;
      m_ovf  = 0;
    end else begin
      m_pre  = mq.size();
      m_push = tx_valid && (m_pre != DEPTH);
      m_ovf  = tx_valid && (m_pre == DEPTH);
      if (m_busy && m_t != FRAME - 1) begin
        m_t++;
      end else if (m_pre != 0) begin
        m_cur  = mq.pop_front();
        m_busy = 1;
        m_t    = 0;
      end else begin
        m_busy = 0;
        m_t    = 0;
      end
      if (m_push) mq.push_back(tx_data);
    end
  end

  function automatic logic model_line();
    if (!m_busy) return 1'b1;
    if (m_t < BPS) return 1'b0;
    if (m_t < 9 * BPS) return m_cur[(m_t - BPS) / BPS];
    return 1'b1;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("line", rs232_tx, model_line());
    check("busy", tx_busy, m_busy);
    check("fifo_cnt", fifo_cnt, mq.size());
    check("ready", tx_ready, mq.size() != DEPTH);
    check("overflow", overflow, m_ovf);
  end

  // Reference receiver sampling at bit centres
  bit         rx_en = 0;
  int         rx_n  = 0;
  logic [7:0] rx_b;
  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_exp;

  initial begin
    forever begin
      @(negedge rs232_tx);
      if (rx_en) begin
        repeat (BPS / 2) @(negedge clk);
        check("rx_start", rs232_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BPS) @(negedge clk);
          rx_b[i] = rs232_tx;
        end
        repeat (BPS) @(negedge clk);
        check("rx_stop", rs232_tx, 1'b1);
        check("rx_pending", rx_exp_q.size() != 0, 1'b1);
        if (rx_exp_q.size() != 0) begin
          rx_exp = rx_exp_q.pop_front();
          check("rx_byte", rx_b, rx_exp);
        end
        rx_n++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((tx_busy || fifo_cnt != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < bound, 1'b1);
  endtask

  logic [7:0] b4 [6];
  int         exp_bits [8];
  int         n, acc_n, ovf_n, idx, sent;
  bit         acc;
  logic [7:0] d;

  initial begin
    b4       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_line", rs232_tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-frame while a zero data bit is on the line
    tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("t1_data_low", rs232_tx, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t1_line_high", rs232_tx, 1'b1);
    check("t1_cnt", fifo_cnt, 0);
    check("t1_ready", tx_ready, 1'b1);
    check("t1_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t1_idle_after", rs232_tx, 1'b1);

    // Single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t2_cnt_queued", fifo_cnt, 1);
    check("t2_line_before", rs232_tx, 1'b1);
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t2_start_first", rs232_tx, 1'b0);
        check("t2_busy_first", tx_busy, 1'b1);
        check("t2_cnt_popped", fifo_cnt, 0);
      end
      if (k == 10) check("t2_start_last", rs232_tx, 1'b0);
      if (k == 11) check("t2_bit0_edge", rs232_tx, 1'b1);
      if (k >= 15 && k <= 85 && (k - 15) % 10 == 0)
        check("t2_bit", rs232_tx, exp_bits[(k - 15) / 10]);
      if (k == 95) check("t2_stop", rs232_tx, 1'b1);
      if (k == 100) check("t2_busy_last", tx_busy, 1'b1);
      if (k == 101) check("t2_busy_end", tx_busy, 1'b0);
    end
    wait_idle(200);

    // Three back-to-back bytes
    tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_data = 8'h55;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t3_cnt_two", fifo_cnt, 2);
    n = 0;
    while (tx_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    // busy rose one edge before this count began: 300 clocks in total
    check("t3_busy_run", n, 299);
    wait_idle(200);

    // Held valid with six bytes while a frame runs
    tx_valid = 1'b1; tx_data = b4[0];
    idx = 0; acc_n = 0; ovf_n = 0;
    for (int c = 0; c < 20; c++) begin
      acc = tx_ready;
      @(negedge clk);
      if (overflow) ovf_n++;
      if (acc) begin
        acc_n++;
        idx++;
      end
      tx_valid = (c < 19) && (idx < 6);
      tx_data  = b4[(idx < 6) ? idx : 5];
    end
    check("t4_accepted", acc_n, 5);
    check("t4_ovf_pulses", ovf_n, 15);
    check("t4_cnt_full", fifo_cnt, 4);
    check("t4_ready_low", tx_ready, 1'b0);

    // Full FIFO at stop-bit end with valid held
    tx_valid = 1'b1; tx_data = 8'h3C;
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_pop_timeout", n < 300, 1'b1);
    check("t5_refused_ovf", overflow, 1'b1);
    check("t5_cnt_after_pop", fifo_cnt, 3);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t5_cnt_refill", fifo_cnt, 4);
    check("t5_ready_low", tx_ready, 1'b0);
    check("t5_no_ovf", overflow, 1'b0);
    wait_idle(1000);

    // 200 random bytes through the reference receiver
    repeat (20) @(negedge clk);
    rx_en = 1;
    sent = 0; n = 0;
    while (sent < 200 && n < 40000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      acc = tx_valid && tx_ready;
      d   = tx_data;
      @(negedge clk);
      n++;
      if (acc) begin
        rx_exp_q.push_back(d);
        sent++;
      end
    end
    tx_valid = 1'b0;
    check("t6_sent", sent, 200);
    n = 0;
    while (rx_n < 200 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("t6_rx_count", rx_n, 200);
    check("t6_rx_left", rx_exp_q.size(), 0);
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
